riscv_fetch_unit: RTL
=====================

# riscv_fetch_unit

Instruction-fetch front end for the RISC-V core, sitting directly upstream of decode. It owns the fetch PC, drives the combinational instruction-memory read port, and queues fetched {PC, instruction} pairs in a small FIFO. Decode pulls pairs through a valid/ready handshake. Branch and jump targets resolved downstream arrive as a redirect that flushes the queue and restarts fetch.

## Interface
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- DEPTH, 2: FIFO entries; power of two, ≥ 2.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- InstMemRAddr  out  32  byte address to instruction memory; equals the fetch PC register.
- InstMemRData  in  32  instruction word; combinational in the same cycle as InstMemRAddr.
- FetchValid  out  1  FIFO head holds a valid pair.
- FetchReady  in  1  decode accepts head this cycle.
- FetchPC  out  32  PC of the head entry; 0 when FetchValid = 0.
- FetchInst  out  32  instruction of the head entry; 0 when FetchValid = 0.
- RedirectValid  in  1  one-cycle redirect request.
- RedirectPC  in  32  new fetch address; bits [1:0] are ignored and treated as 0.

## Operation
- State:
  - fpc (32b).
  - FIFO of DEPTH × 64b entries.
  - rd_ptr, wr_ptr (log2 DEPTH bits, wrap mod DEPTH).
  - count (0..DEPTH).
- Reset: fpc = RESET_PC; rd_ptr = wr_ptr = count = 0.
- Output reset values: InstMemRAddr = RESET_PC, FetchValid = 0, FetchPC = 0, FetchInst = 0.
- pop = FetchValid & FetchReady.
- push = !RedirectValid & (count < DEPTH | pop).
- On push:
  - Write {fpc, InstMemRData} at wr_ptr.
  - wr_ptr++.
  - fpc = fpc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- On pop: rd_ptr++.
- count updates:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Full FIFO with FetchReady = 1: push and pop in the same cycle; count stays at DEPTH (bypass-free, no bubble).
- Redirect has priority over everything:
  - fpc = {RedirectPC[31:2], 2'b00}.
  - rd_ptr = wr_ptr = count = 0.
  - No push that cycle.
  - A head presented in the redirect cycle is flushed. Decode must discard it even if FetchReady = 1.
- No decoding of instruction content. An address past the end of instruction memory returns whatever the memory drives (0 in the bench) and is queued normally.
- Reset asserted mid-operation overrides a redirect and any push/pop in the same cycle.

## Timing
- InstMemRAddr is a registered value (fpc); no combinational path from any input to InstMemRAddr.
- FetchValid, FetchPC and FetchInst come from FIFO state only. FetchReady and RedirectValid have no combinational effect on them.
- After RST deasserts at edge 0: InstMemRAddr = RESET_PC in cycle 0; FetchValid first high in cycle 1 with FetchPC = RESET_PC.
- Steady state with FetchReady held high: one instruction per cycle, consecutive PCs +4.
- Redirect sampled at edge k:
  - InstMemRAddr = target in cycle k+1.
  - FetchValid = 0 in cycle k+1.
  - Target pair valid in cycle k+2.
  - Redirect penalty is 1 bubble cycle.
- With FetchReady low: DEPTH pushes complete, then fpc holds. FetchPC/FetchInst stay stable while FetchValid = 1 and FetchReady = 0.
- Back-to-back redirects on consecutive edges: the last one wins; no entries are queued in between.

## Test plan
- Reset, RESET_PC = 0, FetchReady = 1, memory holds 0x00000393 at 0 and 0x02538663 at 4.
  - Cycle 1: FetchValid = 1, FetchPC = 0, FetchInst = 0x00000393.
  - Cycle 2: FetchPC = 4, FetchInst = 0x02538663.
- Backpressure: FetchReady = 0 from reset.
  - After 2 cycles count = 2 and InstMemRAddr = 8, held.
  - Head stays PC 0 for 10 cycles.
  - Raising FetchReady yields PCs 0, 4, 8, 12 on consecutive cycles with no gap.
- Redirect to 0x10 while streaming at PC 0x8.
  - Next cycle: FetchValid = 0, InstMemRAddr = 0x10.
  - Following cycle: FetchPC = 0x10.
  - No PC 0xC or 0x8 is ever presented after the flush.
- Redirect with RedirectPC = 0x2F issued while the FIFO is full and FetchReady = 0 → fetch resumes at 0x2C; count = 0 the next cycle.
- Wrap: redirect to 32'hFFFF_FFFC with FetchReady = 1 → FetchPC sequence is FFFF_FFFC, 0000_0000, 0000_0004.
- RST asserted for 1 cycle mid-stream, with RedirectValid = 1 in the same cycle → next cycle InstMemRAddr = RESET_PC, FetchValid = 0, FetchPC = 0, FetchInst = 0.

Source files
------------

// File: rtl/riscv_fetch_unit_if.sv
// rtl/riscv_fetch_unit_if.sv - instruction memory, fetch queue and redirect signals of the fetch unit
interface riscv_fetch_unit_if;
    logic [31:0] InstMemRAddr;
    logic [31:0] InstMemRData;
    logic        FetchValid;
    logic        FetchReady;
    logic [31:0] FetchPC;
    logic [31:0] FetchInst;
    logic        RedirectValid;
    logic [31:0] RedirectPC;

    modport master (
        output InstMemRAddr,
        input  InstMemRData,
        output FetchValid,
        input  FetchReady,
        output FetchPC,
        output FetchInst,
        input  RedirectValid,
        input  RedirectPC
    );

    modport slave (
        input  InstMemRAddr,
        output InstMemRData,
        input  FetchValid,
        output FetchReady,
        input  FetchPC,
        input  FetchInst,
        output RedirectValid,
        output RedirectPC
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - fetch PC, instruction memory read and {PC, inst} queue to decode
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                CLK,
    input logic                RST,
    riscv_fetch_unit_if.master fetchBus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fpc;
    logic [63:0]   fifoMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          headValid;
    logic          pop;
    logic          push;
    logic [1:0]    unusedRedirectLsbs;

    assign unusedRedirectLsbs = fetchBus.RedirectPC[1:0];

    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign headValid = (count != '0);
    assign pop       = headValid & fetchBus.FetchReady;
    assign push      = !fetchBus.RedirectValid & ((count < FULL) | pop);

    assign fetchBus.InstMemRAddr = fpc;
    assign fetchBus.FetchValid   = headValid;
    assign fetchBus.FetchPC      = headValid ? fifoMem[rdPtr][63:32] : 32'h0;
    assign fetchBus.FetchInst    = headValid ? fifoMem[rdPtr][31:0]  : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc   <= RESET_PC;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (fetchBus.RedirectValid) begin
            fpc   <= {fetchBus.RedirectPC[31:2], 2'b00};
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fpc   <= fpc + 32'd4;
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: count gates every read of it.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            fifoMem[wrPtr] <= {fpc, fetchBus.InstMemRData};
        end
    end
endmodule
